// File: rtl/count_sequencer.sv
// count_sequencer
//   Run/pause/clear controller for a prescaled two-digit BCD display counter.
//   Owns the clock prescaler and the BCD count, sequences both from three
//   edge-detected button inputs, and emits a one-cycle tick (and wrap) with
//   every count step.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   start_btn  in   start/resume request (level, debounced, synchronised)
//   stop_btn   in   pause request (level)
//   clear_btn  in   clear-to-idle request (level)
//   dir        in   0 = count up, 1 = count down (sampled on the step cycle)
//   digit0     out  BCD ones digit
//   digit1     out  BCD tens digit
//   state      out  00 = IDLE, 01 = RUN, 10 = PAUSE
//   running    out  high exactly when state == RUN
//   tick       out  one-cycle pulse registered with each digit update
//   wrap       out  one-cycle pulse on a terminal wrap, coincides with tick

module count_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int PRE_W    = 26,
    parameter int MAX_VAL  = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clear_btn,
    input  logic       dir,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] state,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSE   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [3:0]       MAX_D1   = 4'(MAX_VAL / 10);
    localparam logic [3:0]       MAX_D0   = 4'(MAX_VAL % 10);

    state_t           state_r;
    state_t           state_nx_s;
    logic [PRE_W-1:0] pre_r;
    logic [PRE_W-1:0] pre_nx_s;
    logic [3:0]       digit0_r;
    logic [3:0]       digit1_r;
    logic [3:0]       d0_nx_s;
    logic [3:0]       d1_nx_s;
    logic             tick_r;
    logic             wrap_r;
    logic             running_r;
    logic             step_s;
    logic             wrap_nx_s;
    logic [8:0]       step_val_s;
    logic             start_q;
    logic             stop_q;
    logic             clear_q;
    logic             start_ev_s;
    logic             stop_ev_s;
    logic             clear_ev_s;

    // Next BCD value for one count step; result is {wrap, tens, ones}.
    function automatic logic [8:0] bcd_step(input logic [3:0] d1,
                                            input logic [3:0] d0,
                                            input logic       down);
        logic [8:0] r;
        if (!down) begin
            if ((d1 == MAX_D1) && (d0 == MAX_D0)) begin
                r = {1'b1, 4'd0, 4'd0};
            end else if (d0 == 4'd9) begin
                r = {1'b0, d1 + 4'd1, 4'd0};
            end else begin
                r = {1'b0, d1, d0 + 4'd1};
            end
        end else begin
            if ((d1 == 4'd0) && (d0 == 4'd0)) begin
                r = {1'b1, MAX_D1, MAX_D0};
            end else if (d0 == 4'd0) begin
                r = {1'b0, d1 - 4'd1, 4'd9};
            end else begin
                r = {1'b0, d1, d0 - 4'd1};
            end
        end
        return r;
    endfunction

    // Rising-edge events: a held level produces only one event.
    assign start_ev_s = start_btn & ~start_q;
    assign stop_ev_s  = stop_btn  & ~stop_q;
    assign clear_ev_s = clear_btn & ~clear_q;

    assign step_val_s = bcd_step(digit1_r, digit0_r, dir);

    // Next-state, prescaler and count logic; clear beats stop beats start.
    always_comb begin
        state_nx_s = state_r;
        pre_nx_s   = pre_r;
        d0_nx_s    = digit0_r;
        d1_nx_s    = digit1_r;
        step_s     = 1'b0;
        wrap_nx_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_ev_s) begin
                    pre_nx_s = '0;
                    d0_nx_s  = 4'd0;
                    d1_nx_s  = 4'd0;
                end else if (start_ev_s) begin
                    state_nx_s = RUN;
                    pre_nx_s   = '0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (clear_ev_s) begin
                    state_nx_s = IDLE;
                    pre_nx_s   = '0;
                    d0_nx_s    = 4'd0;
                    d1_nx_s    = 4'd0;
                end else begin
                    // The prescaler counts this edge even when stop arrives on it;
                    // it is frozen from the following edge onwards.
                    if (pre_r == PRE_LAST) begin
                        pre_nx_s  = '0;
                        step_s    = 1'b1;
                        wrap_nx_s = step_val_s[8];
                        d1_nx_s   = step_val_s[7:4];
                        d0_nx_s   = step_val_s[3:0];
                    end else begin
                        pre_nx_s = pre_r + PRE_W'(1);
                    end
                    if (stop_ev_s) begin
                        state_nx_s = PAUSE;
                    end else begin
                        state_nx_s = RUN;
                    end
                end
            end
            PAUSE: begin
                if (clear_ev_s) begin
                    state_nx_s = IDLE;
                    pre_nx_s   = '0;
                    d0_nx_s    = 4'd0;
                    d1_nx_s    = 4'd0;
                end else if (start_ev_s) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = PAUSE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                pre_nx_s   = '0;
                d0_nx_s    = 4'd0;
                d1_nx_s    = 4'd0;
            end
        endcase
    end

    // State, prescaler, digits, pulses and button history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            pre_r     <= '0;
            digit0_r  <= 4'd0;
            digit1_r  <= 4'd0;
            tick_r    <= 1'b0;
            wrap_r    <= 1'b0;
            running_r <= 1'b0;
            // History set high so a button held through reset needs a re-press.
            start_q   <= 1'b1;
            stop_q    <= 1'b1;
            clear_q   <= 1'b1;
        end else begin
            state_r   <= state_nx_s;
            pre_r     <= pre_nx_s;
            digit0_r  <= d0_nx_s;
            digit1_r  <= d1_nx_s;
            tick_r    <= step_s;
            wrap_r    <= wrap_nx_s;
            running_r <= (state_nx_s == RUN);
            start_q   <= start_btn;
            stop_q    <= stop_btn;
            clear_q   <= clear_btn;
        end
    end

    assign digit0  = digit0_r;
    assign digit1  = digit1_r;
    assign state   = state_r;
    assign running = running_r;
    assign tick    = tick_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer
//   Directed, table-driven bench for count_sequencer with TICK_DIV = 4,
//   MAX_VAL = 12. Each vector holds its inputs for a number of clocks and
//   then compares every output against hand-computed values. Reset
//   behaviour and the held-button-through-reset case are written by hand.

module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       stop_btn;
    logic       clear_btn;
    logic       dir;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [1:0] state;
    logic       running;
    logic       tick;
    logic       wrap;

    int n_vec = 0;
    int n_bad = 0;

    count_sequencer #(
        .TICK_DIV (4),
        .PRE_W    (3),
        .MAX_VAL  (12)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .clear_btn (clear_btn),
        .dir       (dir),
        .digit0    (digit0),
        .digit1    (digit1),
        .state     (state),
        .running   (running),
        .tick      (tick),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       clear;
        logic       dir;
        int         cyc;    // clock edges the inputs are held for
        logic       quiet;  // also require tick=0 and stable digits on every intermediate cycle
        logic [3:0] d1;
        logic [3:0] d0;
        logic [1:0] st;
        logic       tk;
        logic       wr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic p, input logic c, input logic d,
                                input int n, input logic q, input logic [3:0] e1,
                                input logic [3:0] e0, input logic [1:0] es,
                                input logic et, input logic ew);
        vec_t v;
        v.start = s; v.stop = p; v.clear = c; v.dir = d; v.cyc = n; v.quiet = q;
        v.d1 = e1; v.d0 = e0; v.st = es; v.tk = et; v.wr = ew;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] e1, input logic [3:0] e0,
                         input logic [1:0] es, input logic et, input logic ew);
        logic er;
        er = (es == 2'b01);
        n_vec++;
        if ({digit1, digit0, state, running, tick, wrap} !== {e1, e0, es, er, et, ew}) begin
            n_bad++;
            $display("FAIL %s: got d=%0d%0d st=%b run=%b tick=%b wrap=%b, expected d=%0d%0d st=%b run=%b tick=%b wrap=%b",
                     name, digit1, digit0, state, running, tick, wrap, e1, e0, es, er, et, ew);
        end
    endtask

    initial begin
        //  start stop clear dir cyc quiet  d1    d0    st     tick wrap
        add(0, 0, 0, 0,  1, 0, 4'd0, 4'd0, 2'b00, 0, 0); // 0 idle after reset
        add(1, 0, 0, 0,  1, 0, 4'd0, 4'd0, 2'b01, 0, 0); // 1 start -> RUN
        add(0, 0, 0, 0,  3, 0, 4'd0, 4'd0, 2'b01, 0, 0); // 2 prescaler 1..3
        add(0, 0, 0, 0,  1, 0, 4'd0, 4'd1, 2'b01, 1, 0); // 3 first tick, 4 cycles in
        add(0, 0, 0, 0,  1, 0, 4'd0, 4'd1, 2'b01, 0, 0); // 4 tick is one cycle
        add(0, 0, 0, 0, 35, 0, 4'd1, 4'd0, 2'b01, 1, 0); // 5 09 -> 10 carry
        add(0, 0, 0, 0,  4, 0, 4'd1, 4'd1, 2'b01, 1, 0); // 6 11
        add(0, 0, 0, 0,  3, 0, 4'd1, 4'd1, 2'b01, 0, 0); // 7
        add(0, 0, 0, 0,  1, 0, 4'd1, 4'd2, 2'b01, 1, 0); // 8 11 -> 12 no wrap
        add(0, 0, 0, 0,  4, 0, 4'd0, 4'd0, 2'b01, 1, 1); // 9 12 -> 00 wrap
        add(0, 0, 0, 0,  1, 0, 4'd0, 4'd0, 2'b01, 0, 0); // 10 wrap one cycle
        add(0, 0, 0, 1,  3, 0, 4'd1, 4'd2, 2'b01, 1, 1); // 11 down 00 -> 12 wrap
        add(0, 0, 0, 1,  4, 0, 4'd1, 4'd1, 2'b01, 1, 0); // 12
        add(0, 0, 0, 1,  4, 0, 4'd1, 4'd0, 2'b01, 1, 0); // 13
        add(0, 0, 0, 1,  4, 0, 4'd0, 4'd9, 2'b01, 1, 0); // 14 10 -> 09 borrow
        add(0, 0, 0, 0,  1, 0, 4'd0, 4'd9, 2'b01, 0, 0); // 15
        add(0, 1, 0, 0,  1, 0, 4'd0, 4'd9, 2'b10, 0, 0); // 16 stop 2 cycles after tick
        add(0, 1, 0, 0, 10, 1, 4'd0, 4'd9, 2'b10, 0, 0); // 17 paused, held stop
        add(1, 0, 0, 0,  1, 0, 4'd0, 4'd9, 2'b01, 0, 0); // 18 resume
        add(0, 0, 0, 0,  1, 0, 4'd0, 4'd9, 2'b01, 0, 0); // 19
        add(0, 0, 0, 0,  1, 0, 4'd1, 4'd0, 2'b01, 1, 0); // 20 tick 2 cycles after resume
        add(0, 0, 0, 1, 20, 0, 4'd0, 4'd5, 2'b01, 1, 0); // 21 down to 05
        add(0, 0, 0, 0,  3, 0, 4'd0, 4'd5, 2'b01, 0, 0); // 22 dir changed mid-interval
        add(0, 1, 0, 0,  1, 0, 4'd0, 4'd6, 2'b10, 1, 0); // 23 stop on terminal cycle
        add(0, 0, 0, 0,  1, 0, 4'd0, 4'd6, 2'b10, 0, 0); // 24
        add(1, 0, 1, 0,  1, 0, 4'd0, 4'd0, 2'b00, 0, 0); // 25 clear + start -> IDLE
        add(0, 0, 0, 0,  3, 1, 4'd0, 4'd0, 2'b00, 0, 0); // 26
        add(1, 0, 0, 0,  1, 0, 4'd0, 4'd0, 2'b01, 0, 0); // 27
        add(0, 0, 0, 0,  3, 0, 4'd0, 4'd0, 2'b01, 0, 0); // 28
        add(0, 0, 1, 0,  1, 0, 4'd0, 4'd0, 2'b00, 0, 0); // 29 clear on terminal: no step
        add(0, 0, 0, 0,  2, 1, 4'd0, 4'd0, 2'b00, 0, 0); // 30
        add(0, 1, 0, 0,  1, 0, 4'd0, 4'd0, 2'b00, 0, 0); // 31 stop ignored in IDLE
        add(0, 0, 0, 0,  1, 0, 4'd0, 4'd0, 2'b00, 0, 0); // 32
        add(1, 0, 0, 0,  1, 0, 4'd0, 4'd0, 2'b01, 0, 0); // 33
        add(0, 0, 0, 0, 28, 0, 4'd0, 4'd7, 2'b01, 1, 0); // 34 at 07 with tick

        reset = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0; dir = 1'b0;
        #12;
        check("in_reset", 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            start_btn = vecs[i].start;
            stop_btn  = vecs[i].stop;
            clear_btn = vecs[i].clear;
            dir       = vecs[i].dir;
            for (int c = 0; c < vecs[i].cyc; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (vecs[i].quiet && (c < vecs[i].cyc - 1)) begin
                    check($sformatf("vec%0d_quiet%0d", i, c), vecs[i].d1, vecs[i].d0,
                          vecs[i].st, 1'b0, 1'b0);
                end
            end
            check($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d0, vecs[i].st,
                  vecs[i].tk, vecs[i].wr);
        end

        // Mid-RUN reset between edges clears everything at once.
        start_btn = 1'b1;
        #2 reset = 1'b1;
        #1 check("async_reset", 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        // start held across release must not start the counter.
        repeat (3) @(negedge clk);
        check("held_start_ignored", 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
        start_btn = 1'b0;
        @(negedge clk);
        check("start_released", 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
        start_btn = 1'b1;
        @(negedge clk);
        check("start_repressed", 4'd0, 4'd0, 2'b01, 1'b0, 1'b0);
        start_btn = 1'b0;
        repeat (4) @(negedge clk);
        check("tick_after_repress", 4'd0, 4'd1, 2'b01, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
